// File: rtl/ps2_keypad.sv
// PS/2 keyboard receiver and two-player direction decoder.
// Frames are rebuilt from the synchronized PS/2 clock and data lines, then scan codes become held key levels.
module ps2_keypad #(
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       j1_up,
   output logic       j1_down,
   output logic       j1_left,
   output logic       j1_right,
   output logic       j2_up,
   output logic       j2_down,
   output logic       j2_left,
   output logic       j2_right,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       dbg_state
);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   // The synchronizers reset to 1, which is the idle level of the bus.
   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q;
   logic fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
      end
   end

   assign fall = clk_prev_q & ~clk_s2_q;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        start_q, start_d;
   logic        par_q, par_d;
   logic [15:0] idle_q, idle_d;
   logic        frame_ok, frame_bad;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         shift_q <= 8'h00;
         start_q <= 1'b0;
         par_q   <= 1'b0;
         idle_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         start_q <= start_d;
         par_q   <= par_d;
         idle_q  <= idle_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      start_d   = start_q;
      par_d     = par_q;
      idle_d    = idle_q;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      case (state_q)
         IDLE: begin
            idle_d = 16'd0;
            if (fall) begin
               start_d = dat_s2_q;
               cnt_d   = 4'd1;
               state_d = RECV;
            end
         end
         RECV: begin
            if (fall) begin
               idle_d = 16'd0;
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q <= 4'd8) begin
                  shift_d = {dat_s2_q, shift_q[7:1]};
               end else if (cnt_q == 4'd9) begin
                  par_d = dat_s2_q;
               end else begin
                  // Stop bit: odd parity over data plus parity bit.
                  state_d = IDLE;
                  cnt_d   = 4'd0;
                  if (!start_q && dat_s2_q && (^{shift_q, par_q}))
                     frame_ok = 1'b1;
                  else
                     frame_bad = 1'b1;
               end
            end else if (idle_q == TO_LAST) begin
               state_d   = IDLE;
               cnt_d     = 4'd0;
               idle_d    = 16'd0;
               frame_bad = 1'b1;
            end else begin
               idle_d = idle_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // rx_valid is a one-cycle strobe qualifying rx_byte; there is no ready, the consumer must take it.
   logic [7:0] rx_byte_q;
   logic       rx_valid_q, frame_err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_byte_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_valid_q  <= frame_ok;
         frame_err_q <= frame_bad;
         if (frame_ok) rx_byte_q <= shift_q;
      end
   end

   logic       brk_q, ext_q;
   logic [7:0] key_q;
   logic       hit;
   logic [2:0] idx;

   always_comb begin
      hit = 1'b0;
      idx = 3'd0;
      case ({ext_q, rx_byte_q})
         9'h01D: begin hit = 1'b1; idx = 3'd0; end
         9'h01B: begin hit = 1'b1; idx = 3'd1; end
         9'h01C: begin hit = 1'b1; idx = 3'd2; end
         9'h023: begin hit = 1'b1; idx = 3'd3; end
         9'h175: begin hit = 1'b1; idx = 3'd4; end
         9'h172: begin hit = 1'b1; idx = 3'd5; end
         9'h16B: begin hit = 1'b1; idx = 3'd6; end
         9'h174: begin hit = 1'b1; idx = 3'd7; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         brk_q <= 1'b0;
         ext_q <= 1'b0;
         key_q <= 8'h00;
      end else if (frame_err_q) begin
         brk_q <= 1'b0;
         ext_q <= 1'b0;
      end else if (rx_valid_q) begin
         if (rx_byte_q == 8'hF0) begin
            brk_q <= 1'b1;
         end else if (rx_byte_q == 8'hE0) begin
            ext_q <= 1'b1;
         end else begin
            if (hit) key_q[idx] <= ~brk_q;
            brk_q <= 1'b0;
            ext_q <= 1'b0;
         end
      end
   end

   assign {j2_right, j2_left, j2_down, j2_up, j1_right, j1_left, j1_down, j1_up} = key_q;
   assign rx_byte   = rx_byte_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Bench for ps2_keypad: scan-code table, timeout and reset sequences, then random frames against a key-state model.
module tb_ps2_keypad;

   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       j1_up, j1_down, j1_left, j1_right;
   logic       j2_up, j2_down, j2_left, j2_right;
   logic [7:0] rx_byte;
   logic       rx_valid, frame_err, dbg_state;
   logic [7:0] keys;

   ps2_keypad #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .j1_up(j1_up), .j1_down(j1_down), .j1_left(j1_left), .j1_right(j1_right),
      .j2_up(j2_up), .j2_down(j2_down), .j2_left(j2_left), .j2_right(j2_right),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err), .dbg_state(dbg_state)
   );

   assign keys = {j2_right, j2_left, j2_down, j2_up, j1_right, j1_left, j1_down, j1_up};

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // output monitor
   int rv_cnt = 0, err_cnt = 0, kc_cnt = 0;
   int last_rv_cyc = 0, last_err_cyc = 0, last_key_cyc = 0;
   logic [7:0] keys_seen = 8'h00;
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin rv_cnt++; last_rv_cyc = cyc; end
      if (frame_err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
      if (keys !== keys_seen) begin kc_cnt++; last_key_cyc = cyc; end
      keys_seen = keys;
   end

   int n_checks = 0, n_errors = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference model: key levels per bit {j2 r,l,d,u, j1 r,l,d,u}
   logic [7:0] m_keys = 8'h00, m_rx = 8'h00;
   logic       m_brk = 1'b0, m_ext = 1'b0;
   logic [7:0] j1_codes [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
   logic [7:0] j2_codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

   task automatic model_apply(input logic [7:0] b, input logic bad);
      if (bad) begin
         m_brk = 1'b0; m_ext = 1'b0;
      end else begin
         m_rx = b;
         if (b == 8'hF0) m_brk = 1'b1;
         else if (b == 8'hE0) m_ext = 1'b1;
         else begin
            for (int i = 0; i < 4; i++) begin
               if (!m_ext && b == j1_codes[i]) m_keys[i] = !m_brk;
               if (m_ext && b == j2_codes[i]) m_keys[4+i] = !m_brk;
            end
            m_brk = 1'b0; m_ext = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      m_keys = 8'h00; m_rx = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
   endtask

   // driver
   int stop_cyc = 0;
   task automatic send_bits(input logic [7:0] b, input logic bad, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~(^b)) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk); ps2_data = f[i];
         repeat (3) @(negedge clk);
         ps2_clk = 1'b0; stop_cyc = cyc;
         repeat (5) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (3) @(negedge clk);
      end
   endtask

   logic [7:0] exp_keys_prev = 8'h00;
   task automatic check_frame(input logic [7:0] b, input logic bad,
                              input logic [7:0] exp_keys, input logic [7:0] exp_rx);
      int rv0, err0, kc0;
      rv0 = rv_cnt; err0 = err_cnt; kc0 = kc_cnt;
      send_bits(b, bad, 11);
      repeat (3) @(negedge clk);
      if (!bad) begin
         chk("rx_valid_pulses", rv_cnt - rv0, 1);
         chk("rx_valid_cycle", last_rv_cyc - stop_cyc, 3);
         chk("no_frame_err", err_cnt - err0, 0);
      end else begin
         chk("frame_err_pulses", err_cnt - err0, 1);
         chk("frame_err_cycle", last_err_cyc - stop_cyc, 3);
         chk("no_rx_valid", rv_cnt - rv0, 0);
      end
      chk("rx_byte", rx_byte, exp_rx);
      chk("keys", keys, exp_keys);
      chk("key_changes", kc_cnt - kc0, (exp_keys != exp_keys_prev) ? 1 : 0);
      if (exp_keys != exp_keys_prev) chk("key_cycle", last_key_cyc - stop_cyc, 4);
      chk("fsm_idle", dbg_state, 0);
      exp_keys_prev = exp_keys;
   endtask

   typedef struct {
      logic [7:0] b;
      logic       bad;
      logic [7:0] keys;
      logic [7:0] rx;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic [7:0] b, input logic bad, input logic [7:0] k, input logic [7:0] rx);
      vec_t v;
      v.b = b; v.bad = bad; v.keys = k; v.rx = rx;
      tbl.push_back(v);
   endtask

   logic [7:0] pool [13] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B,
                             8'h74, 8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'hEE};

   initial begin
      // W make/break, arrow with/without E0, bad parity, held W+D, prefixes
      add(8'h1D,0,8'h01,8'h1D); add(8'hF0,0,8'h01,8'hF0); add(8'h1D,0,8'h00,8'h1D);
      add(8'hE0,0,8'h00,8'hE0); add(8'h75,0,8'h10,8'h75); add(8'hE0,0,8'h10,8'hE0);
      add(8'hF0,0,8'h10,8'hF0); add(8'h75,0,8'h00,8'h75); add(8'h75,0,8'h00,8'h75);
      add(8'h23,1,8'h00,8'h75); add(8'h23,0,8'h08,8'h23); add(8'h1D,0,8'h09,8'h1D);
      add(8'h1D,0,8'h09,8'h1D); add(8'h23,0,8'h09,8'h23); add(8'h23,0,8'h09,8'h23);
      add(8'hF0,0,8'h09,8'hF0); add(8'h1D,0,8'h08,8'h1D); add(8'hE0,0,8'h08,8'hE0);
      add(8'h1D,0,8'h08,8'h1D); add(8'hAA,0,8'h08,8'hAA); add(8'hFA,0,8'h08,8'hFA);
      add(8'hEE,0,8'h08,8'hEE); add(8'hF0,0,8'h08,8'hF0); add(8'hE0,0,8'h08,8'hE0);
      add(8'h23,0,8'h08,8'h23); add(8'hE0,0,8'h08,8'hE0); add(8'hF0,1,8'h08,8'hE0);
      add(8'h1D,0,8'h09,8'h1D); add(8'hE0,0,8'h09,8'hE0); add(8'h6B,0,8'h49,8'h6B);
      add(8'hF0,0,8'h49,8'hF0); add(8'hE0,0,8'h49,8'hE0); add(8'h6B,0,8'h09,8'h6B);

      // reset
      repeat (3) @(negedge clk);
      chk("reset_keys", keys, 8'h00);
      chk("reset_rx_byte", rx_byte, 8'h00);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_state", dbg_state, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      foreach (tbl[i]) begin
         model_apply(tbl[i].b, tbl[i].bad);
         check_frame(tbl[i].b, tbl[i].bad, tbl[i].keys, tbl[i].rx);
      end

      // timeout after 5 bits, with a pending E0 that the abort must clear
      begin
         int err0;
         model_apply(8'hE0, 0);
         check_frame(8'hE0, 0, m_keys, m_rx);
         err0 = err_cnt;
         send_bits(8'h55, 0, 5);
         repeat (TO + 10) @(negedge clk);
         chk("timeout_err_pulses", err_cnt - err0, 1);
         chk("timeout_state_idle", dbg_state, 0);
         model_apply(8'h00, 1);
         model_apply(8'h75, 0);
         check_frame(8'h75, 0, m_keys, m_rx);
         model_apply(8'h1C, 0);
         check_frame(8'h1C, 0, m_keys, m_rx);
         chk("timeout_j1_left", j1_left, 1);
      end

      // reset mid-frame while j2_left is held
      model_apply(8'hE0, 0); check_frame(8'hE0, 0, m_keys, m_rx);
      model_apply(8'h6B, 0); check_frame(8'h6B, 0, m_keys, m_rx);
      chk("pre_reset_j2_left", j2_left, 1);
      send_bits(8'h1B, 0, 4);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midreset_keys", keys, 8'h00);
      chk("midreset_rx_byte", rx_byte, 8'h00);
      chk("midreset_pulses", {rx_valid, frame_err}, 0);
      chk("midreset_state", dbg_state, 0);
      reset_n = 1'b1;
      model_reset();
      exp_keys_prev = 8'h00;
      repeat (3) @(negedge clk);
      model_apply(8'h1D, 0);
      check_frame(8'h1D, 0, m_keys, m_rx);

      // random scan-code stream against the model
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         logic       bad;
         b = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 12)];
         bad = ($urandom_range(0, 9) == 0);
         model_apply(b, bad);
         check_frame(b, bad, m_keys, m_rx);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_keypad.md
PS2_KEYPAD -- requirements
Module: ps2_keypad

Interface
REQ-001 Parameter TIMEOUT, default 50000, is the number of clk cycles without a PS/2 clock falling edge after which a partially received frame is aborted (2 ms at 25 MHz).
REQ-002 clk  input  1  system clock; all logic is rising-edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-006 j1_up, j1_down, j1_left, j1_right  output  1 each  player-1 key held levels (W, S, A, D).
REQ-007 j2_up, j2_down, j2_left, j2_right  output  1 each  player-2 key held levels (arrow keys, extended codes).
REQ-008 rx_byte  output  8  last correctly received scan-code byte.
REQ-009 rx_valid  output  1  one-cycle pulse when rx_byte is updated.
REQ-010 frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 A falling edge SHALL be detected when the synchronized ps2_clk is 0 and its previous-cycle value is 1; data SHALL be sampled from synchronized ps2_data in the same cycle.
REQ-013 The receiver FSM SHALL have states IDLE and RECV, with an 4-bit bit counter 0..10.
REQ-014 IDLE: on a falling edge, the sampled bit is the start bit; go to RECV with counter = 1; the start-bit value is kept for checking.
REQ-015 RECV: each falling edge stores one bit: counter 1..8 = data LSB-first, 9 = parity, 10 = stop; counter increments on each edge.
REQ-016 On the stop-bit edge the FSM SHALL return to IDLE and check the frame: start = 0, stop = 1, and XOR of 8 data bits and parity = 1 (odd parity).
REQ-017 Valid frame: rx_byte SHALL load the data, and rx_valid SHALL pulse in the cycle after the stop-bit edge is detected (cycle N+1).
REQ-018 Invalid frame: frame_err SHALL pulse at N+1; rx_byte and rx_valid are unchanged; decoder prefix flags are cleared; key outputs are unchanged.
REQ-019 A 16-bit idle counter SHALL reset on every falling edge and increment in RECV; on reaching TIMEOUT, the FSM SHALL go to IDLE, frame_err SHALL pulse once, and prefix flags SHALL clear.
REQ-020 Decoder flags: brk (set by byte F0) and ext (set by byte E0), set in the cycle after rx_valid; they SHALL accumulate in any order (E0 F0 and F0 E0 both accepted).
REQ-021 On any other valid byte, the decoder SHALL look up {ext, byte}, and on a match drive the mapped key to ~brk at cycle N+2; brk and ext SHALL then clear, whether or not a match occurs.
REQ-022 Map without ext: 1D->j1_up, 1B->j1_down, 1C->j1_left, 23->j1_right.
REQ-023 Map with ext: 75->j2_up, 72->j2_down, 6B->j2_left, 74->j2_right.
REQ-024 A non-extended arrow code (e.g. 75 without E0, keypad 8) SHALL NOT affect j2_*; an extended 1D SHALL NOT affect j1_up.
REQ-025 Bytes AA, FA, EE and all unmapped codes SHALL change no key output.
REQ-026 Typematic repeat makes (same code, no F0) SHALL keep the key at 1 with no glitch.
REQ-027 Simultaneous keys, including opposite directions, SHALL be reported independently; priority is the controller's job.

Reset
REQ-028 While reset_n = 0, all outputs SHALL be 0: j1_*, j2_*, rx_byte = 00, rx_valid, frame_err.
REQ-029 While reset_n = 0, the FSM SHALL be IDLE, the counters 0, brk and ext 0, and the synchronizer flops 1 (bus idle).
REQ-030 A reset during RECV SHALL discard the partial frame; the first falling edge after release is treated as a start bit.

Verification
REQ-031 Frame 1D with good parity (parity bit 1) -> rx_valid pulses with rx_byte = 1D; j1_up rises 2 cycles after the stop edge; then F0, 1D -> j1_up = 0.
REQ-032 E0 75 then E0 F0 75 -> j2_up goes 1 then 0; j1_* stay 0; 75 alone -> no output change.
REQ-033 Frame 23 with a flipped parity bit -> frame_err pulses once; j1_right and rx_byte are unchanged; the next good frame decodes normally.
REQ-034 Send 5 bits, then hold ps2_clk high for TIMEOUT+10 cycles -> frame_err pulses exactly once; the following full frame 1C sets j1_left = 1.
REQ-035 Hold W and D (1D, 1D, 23, 23 repeats), then release W -> j1_up and j1_right both 1 until F0 1D, after which only j1_right = 1.
REQ-036 Assert reset_n = 0 mid-frame with j2_left = 1 -> all outputs 0; the next complete frame after release decodes correctly.
